// File: rtl/alu_ctrl_pkg.sv
// rtl/alu_ctrl_pkg.sv - ALU select codes, alu_op classes and sequencer state encoding
package alu_ctrl_pkg;

    localparam logic [2:0] SEL_AND     = 3'b000;
    localparam logic [2:0] SEL_ADD     = 3'b001;
    localparam logic [2:0] SEL_SUB     = 3'b010;
    localparam logic [2:0] SEL_XOR     = 3'b011;
    localparam logic [2:0] SEL_NOR     = 3'b100;
    localparam logic [2:0] SEL_OR      = 3'b101;
    localparam logic [2:0] SEL_SLT     = 3'b110;
    localparam logic [2:0] SEL_MULSTEP = 3'b111;

    localparam logic [2:0] OP_ADDI  = 3'b111;
    localparam logic [2:0] OP_ANDI  = 3'b110;
    localparam logic [2:0] OP_ORI   = 3'b101;
    localparam logic [2:0] OP_NORI  = 3'b100;
    localparam logic [2:0] OP_BEQ   = 3'b011;
    localparam logic [2:0] OP_RTYPE = 3'b010;
    localparam logic [2:0] OP_BRSLT = 3'b001;
    localparam logic [2:0] OP_MEM   = 3'b000;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_HOLD = 2'd1,
        ST_MUL  = 2'd2
    } state_e;

endpackage

// File: rtl/alu_ctrl_decode.sv
// rtl/alu_ctrl_decode.sv - combinational (alu_op, func) to ALU select decoder
// Multiply recognition is enabled by ALU_CTRL_MUL_EN.
module alu_ctrl_decode
    import alu_ctrl_pkg::*;
#(
    parameter int OP_W   = 3,
    parameter int FUNC_W = 3,
    parameter int SEL_W  = 3
) (
    input  logic [OP_W-1:0]   alu_op_i,
    input  logic [FUNC_W-1:0] func_i,
    output logic [SEL_W-1:0]  sel_o,
    output logic              is_mul_o,
    output logic              illegal_o
);

    always_comb begin
        sel_o     = SEL_W'(SEL_ADD);
        is_mul_o  = 1'b0;
        illegal_o = 1'b0;
        case (alu_op_i)
            OP_W'(OP_ADDI), OP_W'(OP_MEM):  sel_o = SEL_W'(SEL_ADD);
            OP_W'(OP_ANDI):                 sel_o = SEL_W'(SEL_AND);
            OP_W'(OP_ORI):                  sel_o = SEL_W'(SEL_OR);
            OP_W'(OP_NORI):                 sel_o = SEL_W'(SEL_NOR);
            OP_W'(OP_BEQ), OP_W'(OP_BRSLT): sel_o = SEL_W'(SEL_SUB);
            OP_W'(OP_RTYPE): begin
                case (func_i)
                    FUNC_W'(0): sel_o = SEL_W'(SEL_AND);
                    FUNC_W'(1): sel_o = SEL_W'(SEL_ADD);
                    FUNC_W'(2): sel_o = SEL_W'(SEL_SUB);
                    FUNC_W'(3): sel_o = SEL_W'(SEL_XOR);
                    FUNC_W'(4): sel_o = SEL_W'(SEL_NOR);
                    FUNC_W'(5): sel_o = SEL_W'(SEL_OR);
                    FUNC_W'(6): sel_o = SEL_W'(SEL_SLT);
`ifdef ALU_CTRL_MUL_EN
                    FUNC_W'(7): begin
                        sel_o    = SEL_W'(SEL_MULSTEP);
                        is_mul_o = 1'b1;
                    end
`endif
                    default:    illegal_o = 1'b1;
                endcase
            end
            default: illegal_o = 1'b1;
        endcase
    end

endmodule

// File: rtl/alu_ctrl_seq.sv
// rtl/alu_ctrl_seq.sv - registered valid/ready ALU control sequencer
// ALU_CTRL_MUL_EN turns R-type func 111 into a MUL_STEPS-beat shift-add burst.
module alu_ctrl_seq
    import alu_ctrl_pkg::*;
#(
    parameter int OP_W      = 3,
    parameter int FUNC_W    = 3,
    parameter int SEL_W     = 3,
    parameter int MUL_STEPS = 8
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic [OP_W-1:0]              alu_op,
    input  logic [FUNC_W-1:0]            func,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [SEL_W-1:0]             alu_sel,
    output logic [$clog2(MUL_STEPS)-1:0] step,
    output logic                         last,
    output logic                         illegal
);

    localparam int STEP_W = $clog2(MUL_STEPS);

    state_e             state_q, state_d;
    logic [SEL_W-1:0]   sel_q, sel_d;
    logic               last_q, last_d;
    logic               illegal_q, illegal_d;
    logic [SEL_W-1:0]   dec_sel;
    logic               dec_is_mul;
    logic               dec_illegal;
    logic               accept;
    logic               out_hs;

    alu_ctrl_decode #(
        .OP_W   (OP_W),
        .FUNC_W (FUNC_W),
        .SEL_W  (SEL_W)
    ) u_decode (
        .alu_op_i  (alu_op),
        .func_i    (func),
        .sel_o     (dec_sel),
        .is_mul_o  (dec_is_mul),
        .illegal_o (dec_illegal)
    );

`ifdef ALU_CTRL_MUL_EN
    logic [STEP_W-1:0] step_q, step_d;
    assign step = step_q;
`else
    assign step = '0;
`endif

    assign out_valid = (state_q != ST_IDLE);
    assign alu_sel   = sel_q;
    assign last      = last_q;
    assign illegal   = illegal_q;
    assign accept    = in_valid & in_ready;
    assign out_hs    = out_valid & out_ready;

    always_comb begin
        state_d   = state_q;
        sel_d     = sel_q;
        last_d    = last_q;
        illegal_d = illegal_q;
        in_ready  = 1'b0;
`ifdef ALU_CTRL_MUL_EN
        step_d    = step_q;
`endif
        case (state_q)
            ST_IDLE: in_ready = 1'b1;
            ST_HOLD: in_ready = out_ready;
            default: in_ready = 1'b0;
        endcase

        // Accept is only possible in IDLE or in HOLD during a consume, so it always wins.
        if (accept) begin
            sel_d     = dec_sel;
            state_d   = ST_HOLD;
            last_d    = 1'b1;
`ifdef ALU_CTRL_MUL_EN
            illegal_d = dec_illegal;
            step_d    = '0;
            if (dec_is_mul) begin
                state_d = ST_MUL;
                last_d  = 1'b0;
            end
`else
            illegal_d = dec_illegal | dec_is_mul;
`endif
        end else if (out_hs) begin
            state_d   = ST_IDLE;
            sel_d     = '0;
            last_d    = 1'b0;
            illegal_d = 1'b0;
`ifdef ALU_CTRL_MUL_EN
            step_d    = '0;
            if (state_q == ST_MUL && !last_q) begin
                state_d = ST_MUL;
                sel_d   = sel_q;
                step_d  = step_q + STEP_W'(1);
                last_d  = (step_q == STEP_W'(MUL_STEPS - 2));
            end
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            sel_q     <= '0;
            last_q    <= 1'b0;
            illegal_q <= 1'b0;
`ifdef ALU_CTRL_MUL_EN
            step_q    <= '0;
`endif
        end else begin
            state_q   <= state_d;
            sel_q     <= sel_d;
            last_q    <= last_d;
            illegal_q <= illegal_d;
`ifdef ALU_CTRL_MUL_EN
            step_q    <= step_d;
`endif
        end
    end

endmodule

// File: tb/tb_alu_ctrl_seq.sv
// tb/tb_alu_ctrl_seq.sv - directed table-driven bench for alu_ctrl_seq (ALU_CTRL_MUL_EN aware)
module tb_alu_ctrl_seq;

    logic       clk;
    logic       reset;
    logic       in_valid;
    logic       in_ready;
    logic [3:0] alu_op;
    logic [2:0] func;
    logic       out_valid;
    logic       out_ready;
    logic [2:0] alu_sel;
    logic [2:0] step;
    logic       last;
    logic       illegal;

    int n_cmp;
    int n_fail;

    // OP_W widened to 4 so that undefined alu_op values exist.
    alu_ctrl_seq #(
        .OP_W      (4),
        .FUNC_W    (3),
        .SEL_W     (3),
        .MUL_STEPS (8)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .alu_op    (alu_op),
        .func      (func),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .alu_sel   (alu_sel),
        .step      (step),
        .last      (last),
        .illegal   (illegal)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [3:0] op;
        logic [2:0] fn;
        logic [2:0] sel;
        logic       ill;
    } vec_t;

    vec_t vt[16];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    initial begin
        n_cmp     = 0;
        n_fail    = 0;
        reset     = 1'b1;
        in_valid  = 1'b0;
        alu_op    = 4'h0;
        func      = 3'h0;
        out_ready = 1'b1;

        for (int i = 0; i < 7; i++) vt[i] = '{4'h2, 3'(i), 3'(i), 1'b0};
        vt[7]  = '{4'h7, 3'h7, 3'b001, 1'b0};
        vt[8]  = '{4'h6, 3'h0, 3'b000, 1'b0};
        vt[9]  = '{4'h5, 3'h3, 3'b101, 1'b0};
        vt[10] = '{4'h4, 3'h0, 3'b100, 1'b0};
        vt[11] = '{4'h3, 3'h0, 3'b010, 1'b0};
        vt[12] = '{4'h1, 3'h6, 3'b010, 1'b0};
        vt[13] = '{4'h0, 3'h0, 3'b001, 1'b0};
        vt[14] = '{4'h8, 3'h0, 3'b001, 1'b1};
        vt[15] = '{4'hF, 3'h2, 3'b001, 1'b1};

        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        chk("rst_out_valid", out_valid, 1'b0);
        chk("rst_alu_sel", alu_sel, 3'b000);
        chk("rst_step", step, 3'd0);
        chk("rst_last", last, 1'b0);
        chk("rst_illegal", illegal, 1'b0);
        chk("rst_in_ready", in_ready, 1'b1);

        // Back-to-back stream, one beat per cycle.
        for (int i = 0; i < 16; i++) begin
            in_valid = 1'b1;
            alu_op   = vt[i].op;
            func     = vt[i].fn;
            tick();
            chk($sformatf("vec%0d_out_valid", i), out_valid, 1'b1);
            chk($sformatf("vec%0d_alu_sel", i), alu_sel, vt[i].sel);
            chk($sformatf("vec%0d_illegal", i), illegal, vt[i].ill);
            chk($sformatf("vec%0d_last", i), last, 1'b1);
            chk($sformatf("vec%0d_in_ready", i), in_ready, 1'b1);
        end
        in_valid = 1'b0;
        tick();
        chk("drain_out_valid", out_valid, 1'b0);

        // Backpressure: held beat must not be replaced by a pending request.
        out_ready = 1'b0;
        in_valid  = 1'b1;
        alu_op    = 4'h6;
        tick();
        alu_op = 4'h7;
        for (int k = 0; k < 5; k++) begin
            chk($sformatf("bp%0d_out_valid", k), out_valid, 1'b1);
            chk($sformatf("bp%0d_alu_sel", k), alu_sel, 3'b000);
            chk($sformatf("bp%0d_in_ready", k), in_ready, 1'b0);
            tick();
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        #1;
        chk("bp_release_in_ready", in_ready, 1'b1);
        tick();
        chk("bp_done_out_valid", out_valid, 1'b0);
        chk("bp_done_in_ready", in_ready, 1'b1);

        // R-type func 111.
        in_valid = 1'b1;
        alu_op   = 4'h2;
        func     = 3'h7;
        tick();
        in_valid = 1'b0;
`ifdef ALU_CTRL_MUL_EN
        for (int k = 0; k < 8; k++) begin
            chk($sformatf("mul%0d_out_valid", k), out_valid, 1'b1);
            chk($sformatf("mul%0d_alu_sel", k), alu_sel, 3'b111);
            chk($sformatf("mul%0d_step", k), step, 3'(k));
            chk($sformatf("mul%0d_last", k), last, (k == 7));
            chk($sformatf("mul%0d_in_ready", k), in_ready, 1'b0);
            tick();
        end
`else
        chk("mul_off_out_valid", out_valid, 1'b1);
        chk("mul_off_alu_sel", alu_sel, 3'b001);
        chk("mul_off_illegal", illegal, 1'b1);
        chk("mul_off_last", last, 1'b1);
        chk("mul_off_step", step, 3'd0);
        tick();
`endif
        chk("mul_end_out_valid", out_valid, 1'b0);
        chk("mul_end_in_ready", in_ready, 1'b1);

        // Reset while a beat is outstanding.
`ifdef ALU_CTRL_MUL_EN
        in_valid = 1'b1;
        alu_op   = 4'h2;
        func     = 3'h7;
        tick();
        in_valid = 1'b0;
        repeat (3) tick();
        chk("midrst_pre_step", step, 3'd3);
`else
        out_ready = 1'b0;
        in_valid  = 1'b1;
        alu_op    = 4'h6;
        tick();
        in_valid = 1'b0;
        chk("midrst_pre_out_valid", out_valid, 1'b1);
`endif
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("midrst_out_valid", out_valid, 1'b0);
        chk("midrst_step", step, 3'd0);
        chk("midrst_last", last, 1'b0);
        chk("midrst_in_ready", in_ready, 1'b1);
        out_ready = 1'b1;
        in_valid  = 1'b1;
        alu_op    = 4'h0;
        func      = 3'h0;
        tick();
        in_valid = 1'b0;
        chk("postrst_out_valid", out_valid, 1'b1);
        chk("postrst_alu_sel", alu_sel, 3'b001);
        tick();
        chk("postrst_drain", out_valid, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/alu_ctrl_seq.md
# alu_ctrl_seq

Registered, handshaked ALU control sequencer that replaces the single-cycle combinational ALU control decoder in the multi-cycle datapath. It accepts one (alu_op, func) pair per valid/ready transaction, decodes it to an ALU select code, and presents that code to the ALU/execute stage one cycle later. Optionally, it expands an R-type multiply into a counted burst of shift-add step beats. It sits between the main control FSM (upstream) and the ALU (downstream).

## Interface
- OP_W, 3, alu_op width
- FUNC_W, 3, R-type function-field width
- SEL_W, 3, ALU select width
- MUL_STEPS, 8, number of shift-add beats per multiply (≥2)
- clk  in  1  clock, all logic on rising edge
- reset  in  1  synchronous, active-high; one clock, sampled only at rising edge of clk
- in_valid  in  1  upstream request valid
- in_ready  out  1  sequencer can accept this cycle
- alu_op  in  OP_W  operation class from main control
- func  in  FUNC_W  R-type function field (ignored unless alu_op=010)
- out_valid  out  1  alu_sel/step/last/illegal valid
- out_ready  in  1  downstream consumes beat
- alu_sel  out  SEL_W  ALU select code
- step  out  $clog2(MUL_STEPS)  beat index within multiply burst, 0 otherwise
- last  out  1  final beat of the current operation
- illegal  out  1  request decoded as illegal (alu_sel forced to ADD)

## Operation
- Select codes: AND=000, ADD=001, SUB=010, XOR=011, NOR=100, OR=101, SLT=110, MULSTEP=111.
- alu_op decode: 111→ADD (addi), 110→AND (andi), 101→OR (ori), 100→NOR (nori), 011→SUB (beq), 001→SUB (bne/slti compare), 000→ADD (lw/sw), 010→R-type by func: 000 AND, 001 ADD, 010 SUB, 011 XOR, 100 NOR, 101 OR, 110 SLT, 111 MUL (see Configuration). An undefined alu_op (for example 3'b... not listed above) sets illegal=1 and alu_sel=ADD.
- FSM states: IDLE (no beat held), HOLD (single beat held), MUL (burst in progress).
- IDLE: in_ready=1. On accept, a single op goes to HOLD; MUL goes to MUL with step=0 and last=0.
- HOLD: in_ready=out_ready. On out handshake, the state goes to HOLD if a new op is accepted in the same cycle, to MUL if the accepted op is MUL, and to IDLE otherwise.
- MUL: in_ready=0. Each out handshake increments step. last=1 when step=MUL_STEPS-1, and the handshake on that beat goes to IDLE.
- Beat fields are stable while out_valid=1 and out_ready=0.

## Timing
- Reset: state=IDLE; out_valid=0, alu_sel=000, step=0, last=0, illegal=0; in_ready=1 in the cycle after reset deasserts.
- Latency: accept at edge N → out_valid=1 after edge N, so the beat is visible in cycle N+1.
- Throughput: one single op per cycle while out_ready=1.
- Multiply: MUL_STEPS beats, then one IDLE cycle before the next accept.
- Simultaneous accept and consume in HOLD: the new beat replaces the old one on the same edge, with no bubble.
- out_ready held low: the output is held indefinitely and in_ready=0.
- reset mid-burst or mid-hold: the beat is discarded and all outputs take reset values at the next edge.
- step wraps only via the return to IDLE and never exceeds MUL_STEPS-1.

## Configuration
- ALU_CTRL_MUL_EN defined: func 111 under alu_op=010 starts a MUL burst as above.
- ALU_CTRL_MUL_EN undefined: the MUL state is removed. func 111 is an illegal single beat (illegal=1, alu_sel=ADD, last=1). step is tied to 0.

## Structure
- Package alu_ctrl_pkg holds:
  - the select-code localparams (SEL_AND … SEL_MULSTEP)
  - the alu_op class localparams (OP_ADDI, OP_ANDI, OP_ORI, OP_NORI, OP_BEQ, OP_BRSLT, OP_MEM, OP_RTYPE)
  - the FSM state enum
- Sub-module alu_ctrl_decode: purely combinational (alu_op, func) → (sel, is_mul, illegal). The sequencer instantiates it once and registers its outputs.

## Test plan
- After reset, alu_op=010 with func=000..110 sent back-to-back, out_ready=1 → out_valid from cycle 1. alu_sel sequence is 000,001,010,011,100,101,110, one per cycle, last=1 every beat, illegal=0.
- I-type/mem/branch classes alu_op=111,110,101,100,011,001,000 → alu_sel 001,000,101,100,010,010,001.
- Backpressure: send alu_op=110, hold out_ready=0 for 5 cycles → alu_sel=000 stable, in_ready=0 throughout. Raise out_ready → one handshake, then in_ready=1.
- With ALU_CTRL_MUL_EN, MUL_STEPS=8, send alu_op=010 func=111 with out_ready=1 → 8 beats of alu_sel=111 with step 0..7, last=1 only at step 7, then in_ready=1. Without the macro → 1 beat with illegal=1, alu_sel=001.
- Assert reset at step=3 of a burst → the next cycle shows out_valid=0, step=0, in_ready=1, and a subsequent alu_op=000 yields alu_sel=001.
- Send an undefined alu_op → illegal=1, alu_sel=001, last=1.
